// File: rtl/ex_div_unit.sv
// ex_div_unit: iterative radix-2 restoring divider living in the EX stage.
// Stalls the pipeline while iterating and keeps the last remainder so a paired REM completes at once.
`ifndef DATA_WIDTH_ALU_OP
`define DATA_WIDTH_ALU_OP 5
`endif
`ifndef ALU_OP_DIV
`define ALU_OP_DIV  5'h10
`endif
`ifndef ALU_OP_DIVU
`define ALU_OP_DIVU 5'h11
`endif
`ifndef ALU_OP_REM
`define ALU_OP_REM  5'h12
`endif
`ifndef ALU_OP_REMU
`define ALU_OP_REMU 5'h13
`endif

module ex_div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6   // 2**CNT_W must exceed DATA_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cpu_en,
  input  logic                          ex_flush,
  input  logic                          id_en,
  input  logic [`DATA_WIDTH_ALU_OP-1:0] id_alu_op,
  input  logic [DATA_W-1:0]             id_alu_in_0,
  input  logic [DATA_W-1:0]             id_alu_in_1,
  input  logic                          rem_after_div,
  output logic                          div_stall,
  output logic                          div_result_valid,
  output logic [DATA_W-1:0]             div_result,
  output logic [1:0]                    dbg_state_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_e;

  localparam logic [DATA_W-1:0] MIN_NEG  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] ALL_ONES = '1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rem_hit_q, rem_hit_d;
  logic [DATA_W-1:0] saved_rem_q, saved_rem_d;
  logic [DATA_W-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic              quo_neg_q, quo_neg_d, rem_neg_q, rem_neg_d;
  logic              is_rem_q, is_rem_d;
  logic [DATA_W-1:0] result_q, result_d;

  logic op_div, op_divu, op_rem, op_remu, div_op, op_signed, op_is_rem;
  assign op_div    = id_alu_op == `ALU_OP_DIV;
  assign op_divu   = id_alu_op == `ALU_OP_DIVU;
  assign op_rem    = id_alu_op == `ALU_OP_REM;
  assign op_remu   = id_alu_op == `ALU_OP_REMU;
  assign div_op    = id_en && (op_div || op_divu || op_rem || op_remu);
  assign op_signed = op_div || op_rem;
  assign op_is_rem = op_rem || op_remu;

  logic              a_neg, b_neg, div_zero, div_ovf, flush, fast_rem, last_step;
  logic [DATA_W-1:0] a_abs, b_abs;
  assign a_neg     = op_signed && id_alu_in_0[DATA_W-1];
  assign b_neg     = op_signed && id_alu_in_1[DATA_W-1];
  assign a_abs     = a_neg ? -id_alu_in_0 : id_alu_in_0;
  assign b_abs     = b_neg ? -id_alu_in_1 : id_alu_in_1;
  assign div_zero  = id_alu_in_1 == '0;
  assign div_ovf   = op_signed && (id_alu_in_0 == MIN_NEG) && (id_alu_in_1 == ALL_ONES);
  assign flush     = cpu_en && ex_flush;
  assign fast_rem  = cpu_en && !ex_flush && (state_q == IDLE) && div_op && op_is_rem && rem_hit_q;
  assign last_step = cnt_q == CNT_W'(DATA_W - 1);

  // Restoring step: a set top bit of the trial means the shifted remainder was below the divisor.
  logic [DATA_W:0] rem_sh, trial;
  assign rem_sh = {rem_q, quo_q[DATA_W-1]};
  assign trial  = rem_sh - {1'b0, dvs_q};

  logic [DATA_W-1:0] quo_fix, rem_fix;
  assign quo_fix = quo_neg_q ? -quo_q : quo_q;
  assign rem_fix = rem_neg_q ? -rem_q : rem_q;

  // Handshake: div_stall holds the ID/EX slot; the cycle with div_stall=0 and
  // div_result_valid=1 is the one in which the slot advances carrying div_result.
  always_comb begin
    div_stall        = 1'b0;
    div_result_valid = 1'b0;
    div_result       = result_q;
    unique case (state_q)
      IDLE: begin
        div_stall = div_op && !fast_rem && !flush;
        if (fast_rem) begin
          div_result_valid = 1'b1;
          div_result       = saved_rem_q;
        end
      end
      CALC: div_stall = !flush;
      DONE: begin
        div_result_valid = !flush;
        div_result       = is_rem_q ? rem_fix : quo_fix;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_hit_d   = rem_hit_q;
    saved_rem_d = saved_rem_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    quo_neg_d   = quo_neg_q;
    rem_neg_d   = rem_neg_q;
    is_rem_d    = is_rem_q;
    result_d    = div_result_valid ? div_result : result_q;
    if (flush) begin
      state_d   = IDLE;
      cnt_d     = '0;
      rem_hit_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fast_rem) begin
            rem_hit_d = 1'b0;
          end else if (div_op) begin
            is_rem_d  = op_is_rem;
            cnt_d     = '0;
            quo_neg_d = 1'b0;
            rem_neg_d = 1'b0;
            if (div_zero) begin
              quo_d   = ALL_ONES;
              rem_d   = id_alu_in_0;
              state_d = DONE;
            end else if (div_ovf) begin
              quo_d   = MIN_NEG;
              rem_d   = '0;
              state_d = DONE;
            end else begin
              quo_d     = a_abs;
              rem_d     = '0;
              dvs_d     = b_abs;
              quo_neg_d = a_neg ^ b_neg;
              rem_neg_d = a_neg;
              state_d   = CALC;
            end
          end else if (id_en) begin
            rem_hit_d = 1'b0;
          end
        end
        CALC: begin
          cnt_d = cnt_q + 1'b1;
          if (!trial[DATA_W]) begin
            rem_d = trial[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], 1'b1};
          end else begin
            rem_d = rem_sh[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], 1'b0};
          end
          if (last_step) state_d = DONE;
        end
        DONE: begin
          saved_rem_d = rem_fix;
          rem_hit_d   = rem_after_div && !is_rem_q;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_hit_q   <= 1'b0;
      saved_rem_q <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      quo_neg_q   <= 1'b0;
      rem_neg_q   <= 1'b0;
      is_rem_q    <= 1'b0;
      result_q    <= '0;
    end else if (cpu_en) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_hit_q   <= rem_hit_d;
      saved_rem_q <= saved_rem_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      quo_neg_q   <= quo_neg_d;
      rem_neg_q   <= rem_neg_d;
      is_rem_q    <= is_rem_d;
      result_q    <= result_d;
    end
  end

  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_ex_div_unit.sv
// tb_ex_div_unit: directed vectors with hand-computed quotients, remainders and stall counts
// for ex_div_unit, including fast REM, special operands, flush, reset and cpu_en freeze.
`timescale 1ns/1ps
`ifndef DATA_WIDTH_ALU_OP
`define DATA_WIDTH_ALU_OP 5
`endif
`ifndef ALU_OP_DIV
`define ALU_OP_DIV  5'h10
`endif
`ifndef ALU_OP_DIVU
`define ALU_OP_DIVU 5'h11
`endif
`ifndef ALU_OP_REM
`define ALU_OP_REM  5'h12
`endif
`ifndef ALU_OP_REMU
`define ALU_OP_REMU 5'h13
`endif

module tb_ex_div_unit;
  localparam int W = 32;
  localparam logic [`DATA_WIDTH_ALU_OP-1:0] OP_ADD = '0;
  localparam logic [`DATA_WIDTH_ALU_OP-1:0] OP_DIV  = `ALU_OP_DIV;
  localparam logic [`DATA_WIDTH_ALU_OP-1:0] OP_DIVU = `ALU_OP_DIVU;
  localparam logic [`DATA_WIDTH_ALU_OP-1:0] OP_REM  = `ALU_OP_REM;
  localparam logic [`DATA_WIDTH_ALU_OP-1:0] OP_REMU = `ALU_OP_REMU;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                          cpu_en = 1'b1;
  logic                          ex_flush = 1'b0;
  logic                          id_en = 1'b0;
  logic [`DATA_WIDTH_ALU_OP-1:0] id_alu_op = '0;
  logic [W-1:0]                  id_alu_in_0 = '0;
  logic [W-1:0]                  id_alu_in_1 = '0;
  logic                          rem_after_div = 1'b0;
  logic                          div_stall, div_result_valid;
  logic [W-1:0]                  div_result;
  logic [1:0]                    dbg_state_o;

  ex_div_unit #(.DATA_W(W), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_en(cpu_en), .ex_flush(ex_flush), .id_en(id_en),
    .id_alu_op(id_alu_op), .id_alu_in_0(id_alu_in_0), .id_alu_in_1(id_alu_in_1),
    .rem_after_div(rem_after_div), .div_stall(div_stall), .div_result_valid(div_result_valid),
    .div_result(div_result), .dbg_state_o(dbg_state_o)
  );

  // scoreboard
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // driver: hold the op in ID/EX until the result cycle; freeze_at>=0 drops cpu_en for 5 cycles
  task automatic do_div(input string tag, input logic [`DATA_WIDTH_ALU_OP-1:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b, input bit rad,
                        input int exp_stall, input logic [W-1:0] exp_res, input int freeze_at);
    int stalls = 0;
    int c = 0;
    bit got = 1'b0;
    logic [W-1:0] e;
    exp_q.push_back(exp_res);
    id_en = 1'b1; id_alu_op = op; id_alu_in_0 = a; id_alu_in_1 = b; rem_after_div = 1'b0;
    while (!got && c < 200) begin
      cpu_en = !(freeze_at >= 0 && c >= freeze_at && c < freeze_at + 5);
      @(negedge clk);
      if (div_result_valid) begin
        got = 1'b1;
        e = exp_q.pop_front();
        check_eq({tag, ".res"}, div_result, e);
        check_eq({tag, ".lat"}, c, exp_stall);
        check_eq({tag, ".stalls"}, stalls, exp_stall);
        check_eq({tag, ".stall_at_valid"}, {31'd0, div_stall}, 0);
        rem_after_div = rad;
      end else if (div_stall) begin
        stalls++;
      end
      @(posedge clk); #1;
      c++;
    end
    rem_after_div = 1'b0; id_en = 1'b0; cpu_en = 1'b1;
    if (!got) begin
      check_eq({tag, ".timeout"}, 0, 1);
      exp_q.delete();
    end
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  int pulses;

  initial begin
    // reset values
    #12;
    check_eq("rst.state", {30'd0, dbg_state_o}, 0);
    check_eq("rst.stall", {31'd0, div_stall}, 0);
    check_eq("rst.valid", {31'd0, div_result_valid}, 0);
    check_eq("rst.result", div_result, 0);
    @(negedge clk); rst_n = 1'b1;
    step();

    // DIVU 100/7 with paired REMU: quotient 14, remainder 2 from the saved value
    do_div("divu100_7", OP_DIVU, 32'd100, 32'd7, 1'b1, 33, 32'd14, -1);
    do_div("remu_fast", OP_REMU, 32'd100, 32'd7, 1'b0, 0, 32'd2, -1);

    // DIV -7/2 = -3, fast REM = -1, then a second REM takes the slow path
    do_div("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 33, 32'hFFFF_FFFD, -1);
    do_div("rem_fast", OP_REM, 32'hFFFF_FFF9, 32'd2, 1'b0, 0, 32'hFFFF_FFFF, -1);
    do_div("rem_slow", OP_REM, 32'hFFFF_FFF9, 32'd2, 1'b0, 33, 32'hFFFF_FFFF, -1);

    // a non-division instruction between DIVU and REMU drops the saved-remainder hit
    do_div("divu20_6", OP_DIVU, 32'd20, 32'd6, 1'b1, 33, 32'd3, -1);
    id_en = 1'b1; id_alu_op = OP_ADD; step(); id_en = 1'b0;
    do_div("remu_after_add", OP_REMU, 32'd20, 32'd6, 1'b0, 33, 32'd2, -1);

    // special operands
    do_div("divu5_0", OP_DIVU, 32'd5, 32'd0, 1'b0, 1, 32'hFFFF_FFFF, -1);
    do_div("remu5_0", OP_REMU, 32'd5, 32'd0, 1'b0, 1, 32'd5, -1);
    do_div("rem_m7_0", OP_REM, 32'hFFFF_FFF9, 32'd0, 1'b0, 1, 32'hFFFF_FFF9, -1);
    do_div("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1, 32'h8000_0000, -1);
    do_div("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1, 32'd0, -1);
    do_div("divu_noovf", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 33, 32'd0, -1);

    // flush at CALC cycle 10
    id_en = 1'b1; id_alu_op = OP_DIVU; id_alu_in_0 = 32'd1000; id_alu_in_1 = 32'd3;
    repeat (10) step();
    ex_flush = 1'b1;
    @(negedge clk);
    check_eq("flush.stall", {31'd0, div_stall}, 0);
    check_eq("flush.valid", {31'd0, div_result_valid}, 0);
    step();
    ex_flush = 1'b0; id_en = 1'b0;
    @(negedge clk);
    check_eq("flush.state", {30'd0, dbg_state_o}, 0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (div_result_valid) pulses++;
    end
    check_eq("flush.no_valid", pulses, 0);
    step();
    do_div("divu1000_3", OP_DIVU, 32'd1000, 32'd3, 1'b0, 33, 32'd333, -1);

    // reset mid-CALC
    id_en = 1'b1; id_alu_op = OP_DIVU; id_alu_in_0 = 32'd1000; id_alu_in_1 = 32'd3;
    repeat (6) step();
    rst_n = 1'b0; id_en = 1'b0;
    #1;
    check_eq("midrst.state", {30'd0, dbg_state_o}, 0);
    check_eq("midrst.stall", {31'd0, div_stall}, 0);
    check_eq("midrst.valid", {31'd0, div_result_valid}, 0);
    check_eq("midrst.result", div_result, 0);
    @(negedge clk); rst_n = 1'b1;
    step();

    // cpu_en low for 5 cycles during CALC delays completion by 5
    do_div("divu_freeze", OP_DIVU, 32'hFFFF_FFFF, 32'd16, 1'b0, 38, 32'h0FFF_FFFF, 10);
    do_div("divu_after", OP_DIVU, 32'd7, 32'd7, 1'b0, 33, 32'd1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
